// File: rtl/rtc_bus_scheduler.sv
// Sequences every RTC access on the shared A/D bus: arbitrates config write-backs
// against the periodic refresh read and walks each sequence's address list.
module rtc_bus_scheduler #(
    parameter int unsigned REFRESH_TICKS = 1000000,
    parameter int unsigned TIMEOUT_CYC   = 255,
    parameter int unsigned GAP_CYC       = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_wr_hora,
    input  logic       req_wr_fecha,
    input  logic       req_wr_timer,
    input  logic       in_flag_done,
    output logic [7:0] out_addr_ram_rtc,
    output logic [3:0] out_addr_mem_local,
    output logic       out_funcion_w_r,
    output logic       out_en_funcion_rtc,
    output logic       out_cmd_phase,
    output logic       busy,
    output logic       err_timeout
);

    localparam int unsigned RCW = (REFRESH_TICKS > 1) ? $clog2(REFRESH_TICKS) : 1;
    localparam int unsigned TCW = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned GCW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [RCW-1:0] REFRESH_LAST = RCW'(REFRESH_TICKS - 1);
    localparam logic [TCW-1:0] TIMEOUT_LAST = TCW'(TIMEOUT_CYC - 1);
    localparam logic [GCW-1:0] GAP_LAST     = GCW'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_GAP
    } state_t;

    typedef enum logic [1:0] {
        SEQ_HORA,
        SEQ_FECHA,
        SEQ_TIMER,
        SEQ_REFRESH
    } seq_t;

    typedef struct packed {
        logic [7:0] addr;
        logic [3:0] mem;
        logic       wr;
        logic       cmd;
    } entry_t;

    // Address/index/direction of entry i within sequence s; write sequences end in a command.
    function automatic entry_t seq_entry(input seq_t s, input logic [3:0] i);
        entry_t e;
        e = '0;
        case (s)
            SEQ_HORA: begin
                e.wr = 1'b1;
                if (i < 4'd3) begin
                    e.addr = 8'h21 + {4'h0, i};
                    e.mem  = i;
                end else begin
                    e.addr = 8'hF1;
                    e.mem  = 4'hF;
                    e.cmd  = 1'b1;
                end
            end
            SEQ_FECHA: begin
                e.wr = 1'b1;
                if (i < 4'd4) begin
                    e.addr = 8'h24 + {4'h0, i};
                    e.mem  = 4'd3 + i;
                end else begin
                    e.addr = 8'hF1;
                    e.mem  = 4'hF;
                    e.cmd  = 1'b1;
                end
            end
            SEQ_TIMER: begin
                e.wr = 1'b1;
                if (i < 4'd3) begin
                    e.addr = 8'h41 + {4'h0, i};
                    e.mem  = 4'd7 + i;
                end else begin
                    e.addr = 8'hF2;
                    e.mem  = 4'hF;
                    e.cmd  = 1'b1;
                end
            end
            default: begin
                e.wr  = 1'b0;
                e.mem = i;
                if (i < 4'd7) begin
                    e.addr = 8'h21 + {4'h0, i};
                end else begin
                    e.addr = 8'h41 + {4'h0, i - 4'd7};
                end
            end
        endcase
        return e;
    endfunction

    function automatic logic seq_last(input seq_t s, input logic [3:0] i);
        case (s)
            SEQ_HORA:  return (i == 4'd3);
            SEQ_FECHA: return (i == 4'd4);
            SEQ_TIMER: return (i == 4'd3);
            default:   return (i == 4'd9);
        endcase
    endfunction

    state_t         state_q, state_d;
    seq_t           seq_q, seq_d;
    logic [3:0]     idx_q, idx_d;
    logic [RCW-1:0] refresh_cnt_q, refresh_cnt_d;
    logic [TCW-1:0] wait_cnt_q, wait_cnt_d;
    logic [GCW-1:0] gap_cnt_q, gap_cnt_d;
    logic           pend_hora_q, pend_hora_d;
    logic           pend_fecha_q, pend_fecha_d;
    logic           pend_timer_q, pend_timer_d;
    logic           pend_refresh_q, pend_refresh_d;
    logic           abort_q, abort_d;
    logic           en_q, en_d;
    logic           wr_q, wr_d;
    logic           cmd_q, cmd_d;
    logic [7:0]     addr_q, addr_d;
    logic [3:0]     mem_q, mem_d;
    logic           busy_q, busy_d;
    logic           err_q, err_d;

    logic           tick;
    logic           ld;
    seq_t           ld_seq;
    logic [3:0]     ld_idx;
    entry_t         nxt;
    logic           clr_hora, clr_fecha, clr_timer, clr_refresh;

    always_comb begin
        state_d     = state_q;
        seq_d       = seq_q;
        idx_d       = idx_q;
        wait_cnt_d  = wait_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        abort_d     = abort_q;
        en_d        = en_q;
        wr_d        = wr_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        mem_d       = mem_q;
        busy_d      = busy_q;
        err_d       = err_q;
        ld          = 1'b0;
        ld_seq      = seq_q;
        ld_idx      = idx_q;
        clr_hora    = 1'b0;
        clr_fecha   = 1'b0;
        clr_timer   = 1'b0;
        clr_refresh = 1'b0;

        tick          = (refresh_cnt_q == REFRESH_LAST);
        refresh_cnt_d = tick ? '0 : refresh_cnt_q + 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (pend_hora_q) begin
                    ld = 1'b1; ld_seq = SEQ_HORA; clr_hora = 1'b1;
                end else if (pend_fecha_q) begin
                    ld = 1'b1; ld_seq = SEQ_FECHA; clr_fecha = 1'b1;
                end else if (pend_timer_q) begin
                    ld = 1'b1; ld_seq = SEQ_TIMER; clr_timer = 1'b1;
                end else if (pend_refresh_q) begin
                    ld = 1'b1; ld_seq = SEQ_REFRESH; clr_refresh = 1'b1;
                end
                if (ld) begin
                    ld_idx = '0;
                    busy_d = 1'b1;
                    err_d  = 1'b0;
                end
            end
            S_ISSUE, S_WAIT: begin
                if (in_flag_done) begin
                    en_d      = 1'b0;
                    cmd_d     = 1'b0;
                    gap_cnt_d = '0;
                    state_d   = S_GAP;
                end else if (state_q == S_WAIT && wait_cnt_q == TIMEOUT_LAST) begin
                    // Abort: the rest of this sequence is dropped, nothing is re-queued.
                    en_d      = 1'b0;
                    cmd_d     = 1'b0;
                    err_d     = 1'b1;
                    abort_d   = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = S_GAP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                    state_d    = S_WAIT;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    if (abort_q || seq_last(seq_q, idx_q)) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        abort_d = 1'b0;
                    end else begin
                        ld     = 1'b1;
                        ld_seq = seq_q;
                        ld_idx = idx_q + 1'b1;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        nxt = seq_entry(ld_seq, ld_idx);
        if (ld) begin
            state_d    = S_ISSUE;
            seq_d      = ld_seq;
            idx_d      = ld_idx;
            wait_cnt_d = '0;
            en_d       = 1'b1;
            addr_d     = nxt.addr;
            mem_d      = nxt.mem;
            wr_d       = nxt.wr;
            cmd_d      = nxt.cmd;
        end

        // A request landing on the same edge its flag is consumed stays pending.
        pend_hora_d    = (pend_hora_q & ~clr_hora) | req_wr_hora;
        pend_fecha_d   = (pend_fecha_q & ~clr_fecha) | req_wr_fecha;
        pend_timer_d   = (pend_timer_q & ~clr_timer) | req_wr_timer;
        pend_refresh_d = (pend_refresh_q & ~clr_refresh) | tick;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            seq_q          <= SEQ_HORA;
            idx_q          <= '0;
            refresh_cnt_q  <= '0;
            wait_cnt_q     <= '0;
            gap_cnt_q      <= '0;
            pend_hora_q    <= 1'b0;
            pend_fecha_q   <= 1'b0;
            pend_timer_q   <= 1'b0;
            pend_refresh_q <= 1'b0;
            abort_q        <= 1'b0;
            en_q           <= 1'b0;
            wr_q           <= 1'b0;
            cmd_q          <= 1'b0;
            addr_q         <= 8'h00;
            mem_q          <= 4'h0;
            busy_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            seq_q          <= seq_d;
            idx_q          <= idx_d;
            refresh_cnt_q  <= refresh_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
            pend_hora_q    <= pend_hora_d;
            pend_fecha_q   <= pend_fecha_d;
            pend_timer_q   <= pend_timer_d;
            pend_refresh_q <= pend_refresh_d;
            abort_q        <= abort_d;
            en_q           <= en_d;
            wr_q           <= wr_d;
            cmd_q          <= cmd_d;
            addr_q         <= addr_d;
            mem_q          <= mem_d;
            busy_q         <= busy_d;
            err_q          <= err_d;
        end
    end

    assign out_addr_ram_rtc   = addr_q;
    assign out_addr_mem_local = mem_q;
    assign out_funcion_w_r    = wr_q;
    assign out_en_funcion_rtc = en_q;
    assign out_cmd_phase      = cmd_q;
    assign busy               = busy_q;
    assign err_timeout        = err_q;

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Directed bench for rtc_bus_scheduler: a responder returns done 3 cycles after each
// en rise, and a scoreboard of expected accesses is checked at every en rise.
`timescale 1ns/1ps
module tb_rtc_bus_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_wr_hora = 1'b0;
    logic       req_wr_fecha = 1'b0;
    logic       req_wr_timer = 1'b0;
    logic       resp_done = 1'b0;
    logic       stim_done = 1'b0;
    logic       in_flag_done;
    logic [7:0] out_addr_ram_rtc;
    logic [3:0] out_addr_mem_local;
    logic       out_funcion_w_r;
    logic       out_en_funcion_rtc;
    logic       out_cmd_phase;
    logic       busy;
    logic       err_timeout;

    assign in_flag_done = resp_done | stim_done;

    typedef struct packed {
        logic [7:0] addr;
        logic [3:0] mem;
        logic       wr;
        logic       cmd;
    } acc_t;

    acc_t exp_q[$];
    acc_t cur_acc = '0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_rise_cyc = 0;
    int   acc_cnt = 0;
    int   withhold_at = 0;
    int   dly = 0;
    logic prev_en = 1'b0;

    rtc_bus_scheduler #(
        .REFRESH_TICKS(100),
        .TIMEOUT_CYC  (255),
        .GAP_CYC      (2)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .req_wr_hora       (req_wr_hora),
        .req_wr_fecha      (req_wr_fecha),
        .req_wr_timer      (req_wr_timer),
        .in_flag_done      (in_flag_done),
        .out_addr_ram_rtc  (out_addr_ram_rtc),
        .out_addr_mem_local(out_addr_mem_local),
        .out_funcion_w_r   (out_funcion_w_r),
        .out_en_funcion_rtc(out_en_funcion_rtc),
        .out_cmd_phase     (out_cmd_phase),
        .busy              (busy),
        .err_timeout       (err_timeout)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed no end of test, required finish before 300us");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks = checks + 1;
        assert (obs === expv) else begin
            errors = errors + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [7:0] a, input logic [3:0] m, input logic w, input logic c);
        acc_t e;
        e.addr = a; e.mem = m; e.wr = w; e.cmd = c;
        exp_q.push_back(e);
    endtask

    task automatic push_refresh();
        for (int i = 0; i < 7; i++) push(8'(8'h21 + i), 4'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) push(8'(8'h41 + i), 4'(7 + i), 1'b0, 1'b0);
    endtask

    task automatic push_hora();
        push(8'h21, 4'd0, 1'b1, 1'b0);
        push(8'h22, 4'd1, 1'b1, 1'b0);
        push(8'h23, 4'd2, 1'b1, 1'b0);
        push(8'hF1, 4'hF, 1'b1, 1'b1);
    endtask

    task automatic push_fecha();
        for (int i = 0; i < 4; i++) push(8'(8'h24 + i), 4'(3 + i), 1'b1, 1'b0);
        push(8'hF1, 4'hF, 1'b1, 1'b1);
    endtask

    task automatic push_timer();
        for (int i = 0; i < 3; i++) push(8'(8'h41 + i), 4'(7 + i), 1'b1, 1'b0);
        push(8'hF2, 4'hF, 1'b1, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n;
        n = 0;
        while (!(busy === 1'b0 && exp_q.size() == 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle_reached"}, 32'(n < limit), 32'd1);
    endtask

    // Responder and scoreboard: compare each access at its en rise, return done 3 cycles later.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            exp_q.delete();
            prev_en   = 1'b0;
            dly       = 0;
            resp_done = 1'b0;
            acc_cnt   = 0;
        end else begin
            resp_done = 1'b0;
            if (dly > 0) begin
                dly = dly - 1;
                if (dly == 0) resp_done = 1'b1;
            end
            if (out_en_funcion_rtc && !prev_en) begin
                acc_cnt       = acc_cnt + 1;
                last_rise_cyc = cyc;
                chk("access_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    cur_acc = exp_q.pop_front();
                    chk("addr_ram_rtc", 32'(out_addr_ram_rtc), 32'(cur_acc.addr));
                    chk("addr_mem_local", 32'(out_addr_mem_local), 32'(cur_acc.mem));
                    chk("funcion_w_r", 32'(out_funcion_w_r), 32'(cur_acc.wr));
                    chk("cmd_phase", 32'(out_cmd_phase), 32'(cur_acc.cmd));
                end
                if (acc_cnt != withhold_at) dly = 2;
            end else if (out_en_funcion_rtc) begin
                chk("addr_stable", 32'(out_addr_ram_rtc), 32'(cur_acc.addr));
                chk("dir_stable", 32'(out_funcion_w_r), 32'(cur_acc.wr));
            end
            prev_en = out_en_funcion_rtc;
        end
    end

    initial begin
        int   n;
        logic any_en;

        repeat (3) @(negedge clk);
        chk("rst_en", 32'(out_en_funcion_rtc), 32'd0);
        chk("rst_w_r", 32'(out_funcion_w_r), 32'd0);
        chk("rst_addr", 32'(out_addr_ram_rtc), 32'h00);
        chk("rst_mem", 32'(out_addr_mem_local), 32'h0);
        chk("rst_cmd", 32'(out_cmd_phase), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Periodic refresh: ten reads
        withhold_at = 0;
        push_refresh();
        wait_idle("refresh", 300);
        chk("refresh_count", 32'(acc_cnt), 32'd10);
        chk("busy_fall_after_gap", 32'(cyc - last_rise_cyc), 32'd5);
        chk("refresh_err", 32'(err_timeout), 32'd0);
        do_reset();

        // Done while idle is ignored; then simultaneous hora+fecha
        stim_done = 1'b1;
        @(negedge clk);
        stim_done = 1'b0;
        any_en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            any_en = any_en | out_en_funcion_rtc | busy;
        end
        chk("idle_done_no_activity", 32'(any_en), 32'd0);
        chk("idle_done_addr", 32'(out_addr_ram_rtc), 32'h00);
        push_hora();
        push_fecha();
        req_wr_hora  = 1'b1;
        req_wr_fecha = 1'b1;
        @(negedge clk);
        req_wr_hora  = 1'b0;
        req_wr_fecha = 1'b0;
        @(negedge clk);
        chk("latency_en", 32'(out_en_funcion_rtc), 32'd1);
        chk("latency_addr", 32'(out_addr_ram_rtc), 32'h21);
        wait_idle("hora_fecha", 200);
        chk("hora_fecha_count", 32'(acc_cnt), 32'd9);
        chk("hora_fecha_cmd_idle", 32'(out_cmd_phase), 32'd0);
        do_reset();

        // Timer requested twice during refresh: one timer sequence afterwards
        push_refresh();
        push_timer();
        n = 0;
        while (busy !== 1'b1 && n < 150) begin
            @(negedge clk);
            n++;
        end
        chk("refresh_started", 32'(n < 150), 32'd1);
        req_wr_timer = 1'b1;
        @(negedge clk);
        req_wr_timer = 1'b0;
        repeat (5) @(negedge clk);
        req_wr_timer = 1'b1;
        @(negedge clk);
        req_wr_timer = 1'b0;
        wait_idle("refresh_timer", 300);
        chk("refresh_timer_count", 32'(acc_cnt), 32'd14);
        any_en = 1'b0;
        repeat (20) begin
            @(negedge clk);
            any_en = any_en | out_en_funcion_rtc;
        end
        chk("no_second_timer", 32'(any_en), 32'd0);
        do_reset();

        // Done withheld on the 2nd hora access: timeout, abort, then timer clears err
        withhold_at = 2;
        push(8'h21, 4'd0, 1'b1, 1'b0);
        push(8'h22, 4'd1, 1'b1, 1'b0);
        push_timer();
        push_refresh();
        req_wr_hora = 1'b1;
        @(negedge clk);
        req_wr_hora = 1'b0;
        repeat (10) @(negedge clk);
        req_wr_timer = 1'b1;
        @(negedge clk);
        req_wr_timer = 1'b0;
        n = 0;
        while (err_timeout !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_seen", 32'(n < 400), 32'd1);
        chk("timeout_en_cycles", 32'(cyc - last_rise_cyc), 32'd255);
        chk("timeout_en_low", 32'(out_en_funcion_rtc), 32'd0);
        chk("timeout_busy", 32'(busy), 32'd1);
        n = 0;
        while (err_timeout !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("err_cleared", 32'(n < 20), 32'd1);
        chk("err_clear_en", 32'(out_en_funcion_rtc), 32'd1);
        chk("err_clear_addr", 32'(out_addr_ram_rtc), 32'h41);
        wait_idle("timeout_seq", 400);
        chk("timeout_seq_count", 32'(acc_cnt), 32'd16);
        do_reset();

        // Reset while waiting for done with a refresh pending
        withhold_at = 1;
        push(8'h21, 4'd0, 1'b1, 1'b0);
        req_wr_hora = 1'b1;
        @(negedge clk);
        req_wr_hora = 1'b0;
        repeat (120) @(negedge clk);
        chk("pre_reset_en", 32'(out_en_funcion_rtc), 32'd1);
        #1;
        reset = 1'b1;
        withhold_at = 0;
        #1;
        chk("mid_rst_en", 32'(out_en_funcion_rtc), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_addr", 32'(out_addr_ram_rtc), 32'h00);
        chk("mid_rst_mem", 32'(out_addr_mem_local), 32'h0);
        chk("mid_rst_w_r", 32'(out_funcion_w_r), 32'd0);
        chk("mid_rst_cmd", 32'(out_cmd_phase), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        push_refresh();
        any_en = out_en_funcion_rtc;
        repeat (99) begin
            @(negedge clk);
            any_en = any_en | out_en_funcion_rtc;
        end
        chk("no_access_before_tick", 32'(any_en), 32'd0);
        @(negedge clk);
        chk("refresh_after_tick_en", 32'(out_en_funcion_rtc), 32'd1);
        chk("refresh_after_tick_addr", 32'(out_addr_ram_rtc), 32'h21);
        wait_idle("post_reset_refresh", 300);
        chk("post_reset_refresh_count", 32'(acc_cnt), 32'd10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
